// File: rtl/pipe_pkg.sv
// Shared pipeline types: operand kinds, forwarding selects
// and the shadow entry tracked for instructions in flight.
package pipe_pkg;

  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_R    = 2'b01,
    KIND_P    = 2'b10,
    KIND_F    = 2'b11
  } kind_e;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MM  = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_ALT = 2'b11;

  typedef struct packed {
    logic             valid;
    kind_e            kind;
    logic [IDX_W-1:0] dst;
    logic             is_load;
  } shadow_t;

  localparam shadow_t SHADOW_NONE = '{
    valid:   1'b0,
    kind:    KIND_NONE,
    dst:     '0,
    is_load: 1'b0
  };

endpackage

// File: rtl/fwd_select.sv
// Match and priority for one ID source against the
// instructions that will be in MM (ex_e) and WB (mm_e).
import pipe_pkg::*;

module fwd_select #(
  parameter int REG_W = 6
) (
  input  logic             valid,
  input  kind_e            kind,
  input  logic [REG_W-1:0] idx,
  input  logic             alt,
  input  shadow_t          ex_e,
  input  shadow_t          mm_e,
  output logic [1:0]       sel,
  output logic             ex_hit,
  output logic             ld_hit
);

  logic used;
  logic mm_hit;

  assign used   = valid && !alt && (kind != KIND_NONE);
  assign ex_hit = used && ex_e.valid && (ex_e.kind == kind)
                  && (ex_e.dst == IDX_W'(idx));
  assign mm_hit = used && mm_e.valid && (mm_e.kind == kind)
                  && (mm_e.dst == IDX_W'(idx));
  assign ld_hit = ex_hit && ex_e.is_load;

  // Newest producer wins; only R sources use the WB path
  always_comb begin
    sel = SEL_REG;
    if (valid && alt)
      sel = SEL_ALT;
    else if (kind == KIND_R && ex_hit)
      sel = SEL_MM;
    else if (kind == KIND_R && mm_hit)
      sel = SEL_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// ID/EX hazard and forwarding controller: shadow pipeline,
// registered mux selects, load-use and multi-cycle stalls.
import pipe_pkg::*;

module hazard_unit #(
  parameter int REG_W = 6,
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [1:0]       id_src1_kind,
  input  logic [1:0]       id_src2_kind,
  input  logic             id_src1_pc,
  input  logic             id_src2_imm,
  input  logic [REG_W-1:0] id_st_src,
  input  logic             id_st_use,
  input  logic             id_st_imm,
  input  logic [REG_W-1:0] id_dst,
  input  logic [1:0]       id_dst_kind,
  input  logic             id_is_load,
  input  logic [LAT_W-1:0] id_latency,
  input  logic             ex_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             p1_mux,
  output logic             p2_mux,
  output logic             f1_mux,
  output logic             f2_mux,
  output logic [1:0]       r1_mux,
  output logic [1:0]       r2_mux,
  output logic [1:0]       wdata_mux
);

  shadow_t ex_e, mm_e, wb_e, id_e;
  logic [LAT_W-1:0] cnt;

  kind_e k1, k2, kst;
  logic [1:0] s1_sel, s2_sel, st_sel;
  logic s1_ex, s2_ex, st_ex;
  logic s1_ld, s2_ld, st_ld;
  logic mc, lu, adv;

  assign k1  = kind_e'(id_src1_kind);
  assign k2  = kind_e'(id_src2_kind);
  assign kst = id_st_use ? KIND_R : KIND_NONE;

  fwd_select #(.REG_W(REG_W)) u_s1 (
    .valid(id_valid), .kind(k1), .idx(id_src1),
    .alt(id_src1_pc), .ex_e(ex_e), .mm_e(mm_e),
    .sel(s1_sel), .ex_hit(s1_ex), .ld_hit(s1_ld)
  );

  fwd_select #(.REG_W(REG_W)) u_s2 (
    .valid(id_valid), .kind(k2), .idx(id_src2),
    .alt(id_src2_imm), .ex_e(ex_e), .mm_e(mm_e),
    .sel(s2_sel), .ex_hit(s2_ex), .ld_hit(s2_ld)
  );

  fwd_select #(.REG_W(REG_W)) u_st (
    .valid(id_valid), .kind(kst), .idx(id_st_src),
    .alt(id_st_imm), .ex_e(ex_e), .mm_e(mm_e),
    .sel(st_sel), .ex_hit(st_ex), .ld_hit(st_ld)
  );

  assign mc        = (cnt != '0) || ex_busy;
  assign lu        = s1_ld || s2_ld || st_ld;
  assign stall_id  = mc || lu;
  assign stall_if  = stall_id;
  assign bubble_ex = lu && !mc;
  assign adv       = !stall_id;

  assign id_e = '{
    valid:   id_valid,
    kind:    kind_e'(id_dst_kind),
    dst:     IDX_W'(id_dst),
    is_load: id_is_load
  };

  // Multi-cycle hold freezes everything; load-use inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_e <= SHADOW_NONE;
      mm_e <= SHADOW_NONE;
      wb_e <= SHADOW_NONE;
    end else if (!mc) begin
      ex_e <= lu ? SHADOW_NONE : id_e;
      mm_e <= ex_e;
      wb_e <= mm_e;
    end
  end

  // EX busy pauses the latency count as well as the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (mc) begin
      if (cnt != '0 && !ex_busy)
        cnt <= cnt - 1'b1;
    end else if (adv && id_valid)
      cnt <= id_latency;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_mux    <= SEL_REG;
      r2_mux    <= SEL_REG;
      wdata_mux <= SEL_REG;
      p1_mux    <= 1'b0;
      p2_mux    <= 1'b0;
      f1_mux    <= 1'b0;
      f2_mux    <= 1'b0;
    end else if (adv) begin
      r1_mux    <= s1_sel;
      r2_mux    <= s2_sel;
      wdata_mux <= st_sel;
      p1_mux    <= s1_ex && (k1 == KIND_P);
      p2_mux    <= s2_ex && (k2 == KIND_P);
      f1_mux    <= s1_ex && (k1 == KIND_F);
      f2_mux    <= s2_ex && (k2 == KIND_F);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed program
// sequences plus randomized traffic against a reference model.
module tb_hazard_unit;

  localparam int REG_W = 6;
  localparam int LAT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid;
  logic [REG_W-1:0] id_src1, id_src2, id_st_src, id_dst;
  logic [1:0] id_src1_kind, id_src2_kind, id_dst_kind;
  logic id_src1_pc, id_src2_imm, id_st_use, id_st_imm;
  logic id_is_load;
  logic [LAT_W-1:0] id_latency;
  logic ex_busy = 1'b0;
  logic stall_if, stall_id, bubble_ex;
  logic p1_mux, p2_mux, f1_mux, f2_mux;
  logic [1:0] r1_mux, r2_mux, wdata_mux;

  hazard_unit #(.REG_W(REG_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_kind(id_src1_kind), .id_src2_kind(id_src2_kind),
    .id_src1_pc(id_src1_pc), .id_src2_imm(id_src2_imm),
    .id_st_src(id_st_src), .id_st_use(id_st_use),
    .id_st_imm(id_st_imm), .id_dst(id_dst),
    .id_dst_kind(id_dst_kind), .id_is_load(id_is_load),
    .id_latency(id_latency), .ex_busy(ex_busy),
    .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .p1_mux(p1_mux), .p2_mux(p2_mux),
    .f1_mux(f1_mux), .f2_mux(f2_mux), .r1_mux(r1_mux),
    .r2_mux(r2_mux), .wdata_mux(wdata_mux)
  );

  always #5 clk = ~clk;

  localparam bit [1:0] KN = 2'd0, KR = 2'd1, KP = 2'd2, KF = 2'd3;

  typedef struct {
    bit v; bit [1:0] k1; int s1; bit [1:0] k2; int s2;
    bit pc; bit imm; int st; bit stu; bit sti;
    bit [1:0] dk; int d; bit ld; int lat;
  } instr_t;

  typedef struct { bit v; bit [1:0] k; int d; bit ld; } ent_t;

  ent_t m_ex = '{0, 0, 0, 0};
  ent_t m_mm = '{0, 0, 0, 0};
  ent_t m_wb = '{0, 0, 0, 0};
  int m_cnt = 0;
  bit [1:0] e_r1 = 0, e_r2 = 0, e_wd = 0;
  bit e_p1 = 0, e_p2 = 0, e_f1 = 0, e_f2 = 0;

  int errs = 0;
  int checks = 0;

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // 0 = no producer in flight, 1 = newest in EX, 2 = newest in MM
  function automatic int where(bit [1:0] k, int idx, bit alt);
    if (!id_valid || alt || k == KN) return 0;
    if (m_ex.v && m_ex.k == k && m_ex.d == idx) return 1;
    if (m_mm.v && m_mm.k == k && m_mm.d == idx) return 2;
    return 0;
  endfunction

  function automatic bit [1:0] rsel(bit [1:0] k, int idx, bit alt);
    if (id_valid && alt) return 2'd3;
    if (k != KR) return 2'd0;
    return 2'(where(k, idx, alt));
  endfunction

  function automatic bit pfsel(bit [1:0] k, int idx, bit alt,
                               bit [1:0] want);
    return (k == want) && (where(k, idx, alt) == 1);
  endfunction

  function automatic bit [1:0] st_kind();
    return id_st_use ? KR : KN;
  endfunction

  function automatic bit exp_mc();
    return (m_cnt > 0) || ex_busy;
  endfunction

  function automatic bit exp_lu();
    if (!(m_ex.v && m_ex.ld)) return 0;
    return where(id_src1_kind, int'(id_src1), id_src1_pc) == 1
        || where(id_src2_kind, int'(id_src2), id_src2_imm) == 1
        || where(st_kind(), int'(id_st_src), id_st_imm) == 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ex <= '{0, 0, 0, 0};
      m_mm <= '{0, 0, 0, 0};
      m_wb <= '{0, 0, 0, 0};
      m_cnt <= 0;
      e_r1 <= 0; e_r2 <= 0; e_wd <= 0;
      e_p1 <= 0; e_p2 <= 0; e_f1 <= 0; e_f2 <= 0;
    end else if (exp_mc()) begin
      if (m_cnt > 0 && !ex_busy) m_cnt <= m_cnt - 1;
    end else begin
      m_wb <= m_mm;
      m_mm <= m_ex;
      if (exp_lu()) begin
        m_ex <= '{0, 0, 0, 0};
      end else begin
        m_ex <= '{id_valid, id_dst_kind, int'(id_dst), id_is_load};
        if (id_valid) m_cnt <= int'(id_latency);
        e_r1 <= rsel(id_src1_kind, int'(id_src1), id_src1_pc);
        e_r2 <= rsel(id_src2_kind, int'(id_src2), id_src2_imm);
        e_wd <= rsel(st_kind(), int'(id_st_src), id_st_imm);
        e_p1 <= pfsel(id_src1_kind, int'(id_src1), id_src1_pc, KP);
        e_p2 <= pfsel(id_src2_kind, int'(id_src2), id_src2_imm, KP);
        e_f1 <= pfsel(id_src1_kind, int'(id_src1), id_src1_pc, KF);
        e_f2 <= pfsel(id_src2_kind, int'(id_src2), id_src2_imm, KF);
      end
    end
  end

  always @(negedge clk) begin
    chk("stall_if", 16'(stall_if), 16'(exp_mc() || exp_lu()));
    chk("stall_id", 16'(stall_id), 16'(exp_mc() || exp_lu()));
    chk("bubble_ex", 16'(bubble_ex), 16'(exp_lu() && !exp_mc()));
    chk("muxes",
        16'({r1_mux, r2_mux, wdata_mux, p1_mux, p2_mux, f1_mux, f2_mux}),
        16'({e_r1, e_r2, e_wd, e_p1, e_p2, e_f1, e_f2}));
  end

  function automatic instr_t op(bit [1:0] dk, int d, bit [1:0] k1,
                                int s1, bit [1:0] k2, int s2,
                                bit ld = 0, int lat = 0);
    instr_t x;
    x = '{1, k1, s1, k2, s2, 0, 0, 0, 0, 0, dk, d, ld, lat};
    return x;
  endfunction

  task automatic drive(instr_t x);
    id_valid     = x.v;
    id_src1_kind = x.k1;
    id_src1      = REG_W'(x.s1);
    id_src2_kind = x.k2;
    id_src2      = REG_W'(x.s2);
    id_src1_pc   = x.pc;
    id_src2_imm  = x.imm;
    id_st_src    = REG_W'(x.st);
    id_st_use    = x.stu;
    id_st_imm    = x.sti;
    id_dst_kind  = x.dk;
    id_dst       = REG_W'(x.d);
    id_is_load   = x.ld;
    id_latency   = LAT_W'(x.lat);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic flush();
    instr_t nop;
    nop = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(nop);
    repeat (3) tick();
  endtask

  function automatic instr_t rnd();
    instr_t x;
    x.v   = ($urandom % 8) != 0;
    x.k1  = 2'($urandom % 4);
    x.s1  = int'($urandom % 4);
    x.k2  = 2'($urandom % 4);
    x.s2  = int'($urandom % 4);
    x.pc  = ($urandom % 8) == 0;
    x.imm = ($urandom % 8) == 0;
    x.st  = int'($urandom % 4);
    x.stu = ($urandom % 4) == 0;
    x.sti = ($urandom % 8) == 0;
    x.dk  = 2'($urandom % 4);
    x.d   = int'($urandom % 4);
    x.ld  = ($urandom % 3) == 0;
    x.lat = (($urandom % 10) == 0) ? int'($urandom_range(1, 4)) : 0;
    return x;
  endfunction

  initial begin
    instr_t x;
    int n;
    bit done;
    flush();
    rst = 1'b1;
    tick();
    chk("reset_stall", 16'({stall_if, stall_id, bubble_ex}), 16'd0);
    chk("reset_mux",
        16'({r1_mux, r2_mux, wdata_mux, p1_mux, p2_mux, f1_mux, f2_mux}),
        16'd0);
    rst = 1'b0;
    tick();

    // add r3 ; add r4,r3,r5
    drive(op(KR, 3, KR, 1, KR, 2));
    #1 chk("mm_fwd_nostall", 16'(stall_id), 16'd0);
    tick();
    drive(op(KR, 4, KR, 3, KR, 5));
    #1 chk("mm_fwd_nostall2", 16'(stall_id), 16'd0);
    tick();
    chk("mm_fwd_r1", 16'(r1_mux), 16'd1);
    chk("mm_fwd_r2", 16'(r2_mux), 16'd0);

    // add r3 ; add r9 ; sub r6,r3,r1
    flush();
    drive(op(KR, 3, KR, 1, KR, 2)); tick();
    drive(op(KR, 9, KR, 1, KR, 1)); tick();
    drive(op(KR, 6, KR, 3, KR, 1)); tick();
    chk("wb_fwd_r1", 16'(r1_mux), 16'd2);

    // add r3 ; or r3 ; xor r7,r3,r3
    flush();
    drive(op(KR, 3, KR, 1, KR, 2)); tick();
    drive(op(KR, 3, KR, 1, KR, 2)); tick();
    drive(op(KR, 7, KR, 3, KR, 3)); tick();
    chk("dual_r1", 16'(r1_mux), 16'd1);
    chk("dual_r2", 16'(r2_mux), 16'd1);

    // ld r2 ; add r4,r2,r1
    flush();
    drive(op(KR, 2, KR, 1, KR, 1, 1)); tick();
    drive(op(KR, 4, KR, 2, KR, 1));
    #1 chk("lu_stall", 16'({stall_if, stall_id, bubble_ex}), 16'h7);
    tick();
    chk("lu_release", 16'({stall_if, stall_id, bubble_ex}), 16'h0);
    tick();
    chk("lu_r1", 16'(r1_mux), 16'd2);

    // fadd lat 7 then integer op
    flush();
    drive(op(KF, 1, KF, 2, KF, 3, 0, 7)); tick();
    drive(op(KR, 8, KR, 1, KR, 1));
    n = 0;
    while (stall_id && n < 30) begin
      n++;
      tick();
    end
    chk("mc_len", 16'(n), 16'd7);

    // same with ex_busy raised for three mid-run cycles
    flush();
    drive(op(KF, 1, KF, 2, KF, 3, 0, 7)); tick();
    drive(op(KR, 8, KR, 1, KR, 1));
    n = 0;
    done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      ex_busy = (c >= 2 && c < 5);
      #1;
      if (stall_id) begin
        n++;
        tick();
      end else done = 1;
    end
    ex_busy = 1'b0;
    chk("mc_busy_len", 16'(n), 16'd10);
    tick();

    // reset during the fadd stall
    flush();
    drive(op(KF, 1, KF, 2, KF, 3, 0, 7)); tick();
    drive(op(KR, 8, KR, 1, KR, 1));
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_stall", 16'({stall_if, stall_id, bubble_ex}), 16'h0);
    chk("rst_mux",
        16'({r1_mux, r2_mux, wdata_mux, p1_mux, p2_mux, f1_mux, f2_mux}),
        16'd0);
    tick();
    rst = 1'b0;
    x = op(KR, 5, KR, 1, KR, 2);
    x.pc = 1;
    x.imm = 1;
    drive(x);
    #1 chk("imm_nostall", 16'(stall_id), 16'd0);
    tick();
    chk("imm_r1", 16'(r1_mux), 16'd3);
    chk("imm_r2", 16'(r2_mux), 16'd3);

    flush();
    repeat (800) begin
      drive(rnd());
      ex_busy = ($urandom % 12) == 0;
      tick();
    end
    ex_busy = 1'b0;
    flush();
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
